// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative shift-add multiplier.
// Results and the zero flag are registered; ready_o drops while a multiply is in progress.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);
    localparam logic [3:0] OP_MUL = 4'b0101;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state, state_next;
    logic             is_mul;
    logic             mul_last;
    logic [SH_W-1:0]  cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] alu_res;

    // Single-cycle ops; mul and unknown codes give 0 here (mul result comes from the iterator).
    function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0] op,
                                                     input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        logic [SH_W-1:0] sh;
        logic [WIDTH-1:0] r;
        sh = b[SH_W-1:0];
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a ^ b;
            4'b0010: r = a << sh;
            4'b0011: r = a + b;
            4'b0100: r = a - b;
            4'b0110: r = a + b;
            4'b0111: r = a >>> sh;
            4'b1000: r = a + b;
            4'b1001: r = a - b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign ready_o  = (state == IDLE);
    assign is_mul   = (ALUCtrl_i == OP_MUL);
    assign mul_last = (cnt == CNT_LAST);
    assign alu_res  = alu_compute(ALUCtrl_i, data1_i, data2_i);
    assign acc_next = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (valid_i && is_mul) state_next = MUL;
                MUL:     if (mul_last) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: flush leaves result_o/zero_o untouched, only kills the op in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            valid_o <= 1'b0;
            if (flush_i) begin
                cnt <= '0;
            end else if (state == IDLE) begin
                if (valid_i) begin
                    if (is_mul) begin
                        mcand  <= data1_i;
                        mplier <= data2_i;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        result_o <= alu_res;
                        zero_o   <= (alu_res == '0);
                        valid_o  <= 1'b1;
                    end
                end
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + SH_W'(1);
                if (mul_last) begin
                    result_o <= acc_next;
                    zero_o   <= (acc_next == '0);
                    valid_o  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result;
    logic        last_zero;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .zero_o    (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic straight from the opcode table.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        logic [63:0] prod;
        sh = b % 32;
        case (op)
            4'd0: return a & b;
            4'd1: return a ^ b;
            4'd2: return a << sh;
            4'd3, 4'd6, 4'd8: return a + b;
            4'd4, 4'd9: return a - b;
            4'd5: begin
                prod = 64'(a) * 64'(b);
                return prod[31:0];
            end
            4'd7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    // Issues one op; non-mul leaves valid_i high so consecutive calls are back-to-back.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] exp;
        int n;
        int ready_low;
        exp = model(op, a, b);
        @(negedge clk_i);
        valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
        @(posedge clk_i); #1;
        if (op == 4'd5) begin
            n = 0;
            ready_low = 0;
            while (!valid_o && n < 100) begin
                if (!ready_o) ready_low++;
                @(posedge clk_i); #1;
                n++;
            end
            check({tag, "_lat"}, 32'(n), 32'(WIDTH));
            check({tag, "_rdylow"}, 32'(ready_low), 32'(WIDTH));
        end
        check({tag, "_vld"}, 32'(valid_o), 32'd1);
        check({tag, "_res"}, result_o, exp);
        check({tag, "_zero"}, 32'(zero_o), 32'(exp == 32'h0));
        last_result = exp;
        last_zero = (exp == 32'h0);
        if (op == 4'd5) idle("mul_pulse");
    endtask

    task automatic idle(input string tag);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check({tag, "_vld0"}, 32'(valid_o), 32'd0);
        check({tag, "_hold"}, result_o, last_result);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_vld"}, 32'(valid_o), 32'd0);
        check({tag, "_res"}, result_o, 32'h0);
        check({tag, "_zero"}, 32'(zero_o), 32'd0);
        check({tag, "_rdy"}, 32'(ready_o), 32'd1);
        last_result = 32'h0;
        last_zero = 1'b0;
    endtask

    logic [31:0] ra, rb;
    logic [3:0]  rop;
    int          pulses;

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
        ALUCtrl_i = 4'd0; data1_i = '0; data2_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_state("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Back-to-back single-cycle ops
        issue(4'd3, 32'd5, 32'd7, "add");
        issue(4'd4, 32'd3, 32'd5, "sub");
        issue(4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "and");
        issue(4'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "xor");
        idle("after_b2b");

        issue(4'd2, 32'd1, 32'd31, "sll");
        issue(4'd7, 32'h8000_0000, 32'd4, "srai");
        issue(4'd2, 32'd1, 32'h25, "sll_sh5");
        issue(4'd9, 32'd9, 32'd9, "beq_eq");
        issue(4'd9, 32'd9, 32'd8, "beq_ne");
        issue(4'd8, 32'h100, 32'hFFFF_FFFC, "lw");
        issue(4'd15, 32'h1234, 32'h5678, "op_f");
        idle("after_dir");

        issue(4'd5, 32'h1234, 32'h5678, "mul");
        issue(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff");

        // Flush at cycle 10 of a mul while valid_i stays high
        @(negedge clk_i);
        valid_i = 1'b1; ALUCtrl_i = 4'd5; data1_i = 32'd3; data2_i = 32'd4;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1; ALUCtrl_i = 4'd3;
        @(posedge clk_i); #1;
        check("flush_vld", 32'(valid_o), 32'd0);
        check("flush_rdy", 32'(ready_o), 32'd1);
        check("flush_hold", result_o, last_result);
        check("flush_zhold", 32'(zero_o), 32'(last_zero));
        @(negedge clk_i);
        flush_i = 1'b0;
        issue(4'd3, 32'd100, 32'd23, "add_post_flush");
        @(negedge clk_i);
        valid_i = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o) pulses++;
        end
        check("flush_no_pulse", 32'(pulses), 32'd0);

        // Reset during a multiply
        @(negedge clk_i);
        valid_i = 1'b1; ALUCtrl_i = 4'd5; data1_i = 32'd7; data2_i = 32'd9;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_reset_state("rst_mul");
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b0;

        // Reset on the same edge as a single-cycle accept
        issue(4'd3, 32'd1, 32'd2, "pre_rst");
        @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b1; ALUCtrl_i = 4'd3; data1_i = 32'd10; data2_i = 32'd20;
        @(posedge clk_i); #1;
        check_reset_state("rst_accept");
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b0;

        // Randomized ops, multiplies included
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = pick_operand();
            rb = pick_operand();
            issue(rop, ra, rb, "rand");
            if ($urandom_range(0, 3) == 0) idle("rand_gap");
        end
        idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
